hex_entry_buttons: RTL

- Input-side counterpart of the 8-digit hex display driver: turns the five board push-buttons into a 32-bit hex value entered digit by digit.
- Feeds `display_value` into the display driver's 32-bit number input and feeds `number_out` plus `load` to downstream logic (target hash / start value).
- Debounces and edge-detects every button, then runs a small IDLE/EDIT state machine over a working register.

---
 rtl/hex_entry_buttons_pkg.sv | 32 +++
 rtl/hex_entry_buttons_if.sv | 28 ++
 rtl/hex_entry_buttons_debouncer.sv | 49 ++++
 rtl/hex_entry_buttons.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/hex_entry_buttons_pkg.sv
// Shared types and constants for the push-button hex entry block.
// Pure declarations: no latency, no flow control.
package hex_entry_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EDIT = 1'b1
   } state_e;

   localparam int BTN_IDX_CENTER = 0;
   localparam int BTN_IDX_UP     = 1;
   localparam int BTN_IDX_DOWN   = 2;
   localparam int BTN_IDX_LEFT   = 3;
   localparam int BTN_IDX_RIGHT  = 4;

   localparam int NUM_BTNS = 5;
   localparam int DIGITS   = 8;
   localparam int CUR_W    = $clog2(DIGITS);

   // Steps one nibble by +/-1 modulo 16; neighbouring nibbles never see a carry.
   function automatic logic [4*DIGITS-1:0] nibble_step(input logic [4*DIGITS-1:0] v,
                                                       input logic [CUR_W-1:0]    idx,
                                                       input logic                dn);
      logic [4*DIGITS-1:0] r;
      logic [3:0]          n;
      r = v;
      n = v[{idx, 2'b00} +: 4];
      r[{idx, 2'b00} +: 4] = dn ? (n - 4'd1) : (n + 4'd1);
      return r;
   endfunction

endpackage

// File: rtl/hex_entry_buttons_if.sv
// Raw button inputs and entry-state outputs of the hex entry block.
// Wires only: no latency, no flow control.
interface hex_entry_buttons_if;
   import hex_entry_pkg::*;

   logic                      BTN_UP;
   logic                      BTN_DOWN;
   logic                      BTN_LEFT;
   logic                      BTN_RIGHT;
   logic                      BTN_CENTER;
   logic [4*DIGITS-1:0]       number_out;
   logic [4*DIGITS-1:0]       display_value;
   logic [CUR_W-1:0]          cursor;
   logic [DIGITS-1:0]         cursor_mask;
   logic                      editing;
   logic                      load;

   modport master (
      output BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER,
      input  number_out, display_value, cursor, cursor_mask, editing, load
   );

   modport slave (
      input  BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTER,
      output number_out, display_value, cursor, cursor_mask, editing, load
   );

endinterface

// File: rtl/hex_entry_buttons_debouncer.sv
// One button: 2-FF synchronizer, stability counter, registered press pulse on the debounced rising edge.
// Press pulse lags the raw edge by 2 sync cycles plus DEBOUNCE_CYCLES; no backpressure.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          deb_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            // Level has differed long enough; only the 0->1 transition is an event.
            deb_q   <= sync2_q;
            cnt_q   <= '0;
            press_q <= sync2_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign level_o = deb_q;
   assign press_o = press_q;

endmodule

// File: rtl/hex_entry_buttons.sv
// Five push-buttons to a 32-bit hex value edited digit by digit (IDLE/EDIT FSM); optional HEX_ENTRY_AUTOREPEAT_EN.
// Outputs reflect a press one cycle after its registered event; no backpressure, one action per cycle.
module hex_entry_buttons
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic                CLK,
   input  logic                RESETN,
   hex_entry_buttons_if.slave  bus
);

   logic [NUM_BTNS-1:0] btn_raw;
   logic [NUM_BTNS-1:0] btn_lvl;
   logic [NUM_BTNS-1:0] btn_press;
   logic [NUM_BTNS-1:0] btn_ev;

   assign btn_raw[BTN_IDX_CENTER] = bus.BTN_CENTER;
   assign btn_raw[BTN_IDX_UP]     = bus.BTN_UP;
   assign btn_raw[BTN_IDX_DOWN]   = bus.BTN_DOWN;
   assign btn_raw[BTN_IDX_LEFT]   = bus.BTN_LEFT;
   assign btn_raw[BTN_IDX_RIGHT]  = bus.BTN_RIGHT;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i   (CLK),
         .rst_ni  (RESETN),
         .btn_i   (btn_raw[g]),
         .level_o (btn_lvl[g]),
         .press_o (btn_press[g])
      );
   end

   state_e              state_q, state_d;
   logic [4*DIGITS-1:0] num_q, num_d;
   logic [4*DIGITS-1:0] edit_q, edit_d;
   logic [CUR_W-1:0]    cur_q, cur_d;
   logic                load_q, load_d;

`ifdef HEX_ENTRY_AUTOREPEAT_EN
   logic [31:0] hold_cnt_q, hold_cnt_d;
   logic        hold_act_q, hold_act_d;
   logic        hold_dn_q, hold_dn_d;
   logic        held;
   logic        rep_ev;

   assign held   = hold_dn_q ? btn_lvl[BTN_IDX_DOWN] : btn_lvl[BTN_IDX_UP];
   // A real event in the same cycle cancels the hold, so no synthetic event then.
   assign rep_ev = (state_q == EDIT) && hold_act_q && held && (btn_press == '0) &&
                   (hold_cnt_q == 32'(REPEAT_DELAY));

   always_comb begin
      btn_ev = btn_press;
      if (rep_ev) begin
         btn_ev[hold_dn_q ? BTN_IDX_DOWN : BTN_IDX_UP] = 1'b1;
      end
   end

   // hold_cnt counts cycles since the press event; it rewinds by one period after each repeat.
   always_comb begin
      hold_act_d = 1'b0;
      hold_cnt_d = '0;
      hold_dn_d  = hold_dn_q;
      if ((state_q == EDIT) && !btn_press[BTN_IDX_CENTER] &&
          (btn_press[BTN_IDX_UP] || btn_press[BTN_IDX_DOWN])) begin
         hold_act_d = 1'b1;
         hold_cnt_d = 32'd1;
         hold_dn_d  = !btn_press[BTN_IDX_UP];
      end else if ((state_q == EDIT) && hold_act_q && held && (btn_press == '0)) begin
         hold_act_d = 1'b1;
         hold_cnt_d = rep_ev ? 32'(REPEAT_DELAY - REPEAT_PERIOD + 1) : (hold_cnt_q + 32'd1);
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         hold_cnt_q <= '0;
         hold_act_q <= 1'b0;
         hold_dn_q  <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         hold_act_q <= hold_act_d;
         hold_dn_q  <= hold_dn_d;
      end
   end
`else
   logic unused_cfg;

   assign btn_ev     = btn_press;
   assign unused_cfg = ^{btn_lvl, (REPEAT_DELAY > 0), (REPEAT_PERIOD > 0)};
`endif

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q <= IDLE;
         num_q   <= '0;
         edit_q  <= '0;
         cur_q   <= '0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         edit_q  <= edit_d;
         cur_q   <= cur_d;
         load_q  <= load_d;
      end
   end

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      edit_d  = edit_q;
      cur_d   = cur_q;
      load_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_ev[BTN_IDX_CENTER]) begin
               edit_d  = num_q;
               cur_d   = '0;
               state_d = EDIT;
            end
         end
         EDIT: begin
            if (btn_ev[BTN_IDX_CENTER]) begin
               num_d   = edit_q;
               load_d  = 1'b1;
               state_d = IDLE;
            end else if (btn_ev[BTN_IDX_UP]) begin
               edit_d = nibble_step(edit_q, cur_q, 1'b0);
            end else if (btn_ev[BTN_IDX_DOWN]) begin
               edit_d = nibble_step(edit_q, cur_q, 1'b1);
            end else if (btn_ev[BTN_IDX_LEFT]) begin
               cur_d = cur_q + 1'b1;
            end else if (btn_ev[BTN_IDX_RIGHT]) begin
               cur_d = cur_q - 1'b1;
            end
         end
      endcase
   end

   assign bus.number_out    = num_q;
   assign bus.display_value = (state_q == EDIT) ? edit_q : num_q;
   assign bus.cursor        = cur_q;
   assign bus.cursor_mask   = (state_q == EDIT) ? ~(DIGITS'(1) << cur_q) : '1;
   assign bus.editing       = (state_q == EDIT);
   assign bus.load          = load_q;

endmodule
